l1_i_controller_nway: RTL
=========================

L1_I_CONTROLLER_NWAY -- requirements
Module: l1_i_controller_nway

Interface
REQ-001 SHALL have parameter WAYS, default 4, associativity (power of two, 2..8).
REQ-002 SHALL have parameter TNUM, default 21, L1 tag bits.
REQ-003 SHALL have parameter INUM, default 26-TNUM, L1 index bits.
REQ-004 SHALL have parameters TNUM_2 (default 18) and INUM_2 (default 26-TNUM_2), L2 tag/index bits; TNUM+INUM == TNUM_2+INUM_2 is a legal-configuration requirement.
REQ-005 SHALL have one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 tag_C_L1  in  TNUM  request tag from core.
REQ-009 index_C_L1  in  INUM  request set index.
REQ-010 read_C_L1  in  1  core read request, level.
REQ-011 flush  in  1  invalidate-all request, level.
REQ-012 ready_L2_L1  in  1  L2 data-return strobe.
REQ-013 stall  out  1  core must hold request.
REQ-014 refill  out  1  one-cycle data-array write strobe.
REQ-015 way  out  $clog2(WAYS)  hit way (lookup) or victim way (refill).
REQ-016 read_L1_L2  out  1  miss request to L2.
REQ-017 index_L1_L2  out  INUM_2  and tag_L1_L2  out  TNUM_2  = {tag,index} of captured miss re-split at L2 boundary.

Function
REQ-018 SHALL hold per-set WAYS tag+valid entries and a WAYS-1-bit tree pseudo-LRU per set.
REQ-019 SHALL implement states IDLE, MISS, REFILL, FLUSH.
REQ-020 IDLE: hit = read_C_L1 && any valid way with matching tag; hit is combinational, stall=0, way=hit way, PLRU updated to hit way at next edge.
REQ-021 IDLE miss: stall=1 same cycle; next edge captures tag/index, selects victim (lowest-numbered invalid way, else PLRU victim), enters MISS.
REQ-022 MISS: read_L1_L2=1, L2 address stable, stall=1; ready_L2_L1 -> REFILL next edge; no timeout.
REQ-023 REFILL (exactly one cycle): refill=1, way=victim, stall=1; writes tag, sets valid, points PLRU away from victim; -> IDLE.
REQ-024 Refill-to-release latency: refill falls, stall falls one cycle later via IDLE re-lookup hit (core holds address).
REQ-025 ready_L2_L1 in IDLE, REFILL or FLUSH SHALL be ignored.
REQ-026 flush in IDLE SHALL have priority over read_C_L1: stall=1, -> FLUSH; FLUSH clears all valid and PLRU bits in one cycle, stays while flush=1, -> IDLE when flush=0.
REQ-027 flush during MISS/REFILL SHALL be deferred: transaction completes normally, then FLUSH entered from IDLE if flush still high.
REQ-028 Changes of tag_C_L1/index_C_L1 during MISS/REFILL SHALL not affect the captured request.
REQ-029 read_C_L1=0 in IDLE: stall=0, no state change.

Reset
REQ-030 rst SHALL asynchronously force IDLE, clear all valid and PLRU bits, captured tag/index=0.
REQ-031 Under reset outputs SHALL be stall=0, refill=0, read_L1_L2=0, way=0, index_L1_L2=0, tag_L1_L2=0.
REQ-032 rst mid-MISS/REFILL SHALL abandon the transaction; no entry installed.

Structure
REQ-033 State enum and PLRU victim/update helper functions SHALL live in shared package l1_cache_pkg.
REQ-034 Tree-PLRU SHALL be sub-module plru_tree (WAYS param; inputs access way, access strobe; output victim).
REQ-035 Tag/valid storage SHALL be flops (flush must clear in one cycle).

Verification (WAYS=4, TNUM=21, INUM=5)
REQ-036 Cold read index 3, tag 0x1A: stall=1, read_L1_L2 until ready_L2_L1 pulse, refill one cycle way=0, stall low next cycle.
REQ-037 Fill ways 0-3 of index 3 with tags 0x10..0x13, reread each -> stall=0 same cycle, way=0..3.
REQ-038 Set full, read tags 0x10,0x12 then miss tag 0x20 -> victim way 1 (PLRU), refill way=1.
REQ-039 flush=1 for 3 cycles then read 0x10 at index 3 -> miss, refill way=0.
REQ-040 flush asserted in MISS -> refill completes, then FLUSH; subsequent read of refilled tag misses.
REQ-041 rst pulsed in MISS -> read_L1_L2=0 immediately; re-request same address -> miss, way=0.

Source files
------------

// File: rtl/l1_cache_pkg.sv
// Shared types and tree pseudo-LRU helpers for the N-way L1 instruction cache controller.
// Trees are heap-ordered (node n has children 2n+1 / 2n+2); a bit of 0 points the victim left.
package l1_cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MISS   = 2'd1,
    ST_REFILL = 2'd2,
    ST_FLUSH  = 2'd3
  } l1_state_e;

  // Trees up to 8 ways: at most 7 node bits, 3 levels, 3-bit way numbers.
  localparam int PLRU_MAX_LEVELS = 3;

  // Walk from the root following the node bits; each level contributes one way bit, MSB first.
  function automatic logic [2:0] plru_victim(input logic [1:0] levels, input logic [6:0] tree);
    logic [2:0] v;
    logic [2:0] node;
    logic [1:0] pos;
    logic       b;
    v    = '0;
    node = '0;
    pos  = '0;
    b    = 1'b0;
    for (int lvl = 0; lvl < PLRU_MAX_LEVELS; lvl++) begin
      if (2'(lvl) < levels) begin
        pos    = levels - 2'd1 - 2'(lvl);
        b      = tree[node];
        v[pos] = b;
        node   = {node[1:0], 1'b0} + 3'd1 + {2'b00, b};
      end
    end
    return v;
  endfunction

  // Make every node on the path to acc_way point at the opposite subtree.
  function automatic logic [6:0] plru_update(input logic [1:0] levels, input logic [6:0] tree,
                                             input logic [2:0] acc_way);
    logic [6:0] t;
    logic [2:0] node;
    logic [1:0] pos;
    logic       b;
    t    = tree;
    node = '0;
    pos  = '0;
    b    = 1'b0;
    for (int lvl = 0; lvl < PLRU_MAX_LEVELS; lvl++) begin
      if (2'(lvl) < levels) begin
        pos     = levels - 2'd1 - 2'(lvl);
        b       = acc_way[pos];
        t[node] = ~b;
        node    = {node[1:0], 1'b0} + 3'd1 + {2'b00, b};
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/l1_i_controller_nway_if.sv
// Core-side and L2-side signals of the L1 instruction cache controller.
interface l1_i_controller_nway_if #(
  parameter int WAYS   = 4,
  parameter int TNUM   = 21,
  parameter int INUM   = 26 - TNUM,
  parameter int TNUM_2 = 18,
  parameter int INUM_2 = 26 - TNUM_2
) ();

  // Handshake: the core holds tag/index/read_C_L1 steady for as long as stall is high; the
  // request completes in the first cycle where read_C_L1=1 and stall=0 (way then names the hit
  // way). read_L1_L2 is a level with a stable L2 address until a single-cycle ready_L2_L1 strobe
  // is seen; refill is a one-cycle data-array write strobe into way.
  logic [TNUM-1:0]         tag_C_L1;
  logic [INUM-1:0]         index_C_L1;
  logic                    read_C_L1;
  logic                    flush;
  logic                    ready_L2_L1;
  logic                    stall;
  logic                    refill;
  logic [$clog2(WAYS)-1:0] way;
  logic                    read_L1_L2;
  logic [INUM_2-1:0]       index_L1_L2;
  logic [TNUM_2-1:0]       tag_L1_L2;

  modport slave (
    input  tag_C_L1, index_C_L1, read_C_L1, flush, ready_L2_L1,
    output stall, refill, way, read_L1_L2, index_L1_L2, tag_L1_L2
  );

  modport master (
    output tag_C_L1, index_C_L1, read_C_L1, flush, ready_L2_L1,
    input  stall, refill, way, read_L1_L2, index_L1_L2, tag_L1_L2
  );

endinterface

// File: rtl/plru_tree.sv
// Per-set tree pseudo-LRU state: victim lookup for the addressed set, update on access, bulk clear.
module plru_tree
  import l1_cache_pkg::*;
#(
  parameter int WAYS = 4,
  parameter int SETS = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic [$clog2(SETS)-1:0] index,
  input  logic                    access,
  input  logic [$clog2(WAYS)-1:0] access_way,
  output logic [$clog2(WAYS)-1:0] victim
);

  localparam int WL = $clog2(WAYS);

  logic [WAYS-2:0] bits_q [SETS];
  logic [WAYS-2:0] bits_d [SETS];
  logic [6:0]      tree_cur;
  logic [6:0]      tree_upd;
  logic [2:0]      victim_full;
  logic            unused_bits;

  always_comb begin
    tree_cur    = 7'(bits_q[index]);
    tree_upd    = plru_update(2'(WL), tree_cur, 3'(access_way));
    victim_full = plru_victim(2'(WL), tree_cur);
  end

  assign victim      = victim_full[WL-1:0];
  assign unused_bits = ^{victim_full, tree_upd};

  // Clear wins over a same-cycle access so a flush leaves every set uniform.
  always_comb begin
    bits_d = bits_q;
    if (clear) begin
      for (int s = 0; s < SETS; s++) bits_d[s] = '0;
    end else if (access) begin
      bits_d[index] = tree_upd[WAYS-2:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) bits_q[s] <= '0;
    end else begin
      bits_q <= bits_d;
    end
  end

endmodule

// File: rtl/l1_i_controller_nway.sv
// N-way set-associative L1 instruction cache controller: tag/valid lookup, miss request to L2,
// one-cycle refill with invalid-first / tree-PLRU victim choice, and single-cycle flush.
module l1_i_controller_nway
  import l1_cache_pkg::*;
#(
  parameter int WAYS   = 4,
  parameter int TNUM   = 21,
  parameter int INUM   = 26 - TNUM,
  parameter int TNUM_2 = 18,
  parameter int INUM_2 = 26 - TNUM_2
) (
  input  logic      clk,
  input  logic      rst,
  l1_i_controller_nway_if.slave bus,
  output l1_state_e state_dbg
);

  localparam int WL   = $clog2(WAYS);
  localparam int SETS = 1 << INUM;

  l1_state_e         state_q, state_d;
  logic [TNUM-1:0]   cap_tag_q, cap_tag_d;
  logic [INUM-1:0]   cap_index_q, cap_index_d;
  logic [WL-1:0]     victim_q, victim_d;
  logic [TNUM-1:0]   tag_q [SETS][WAYS];
  logic [TNUM-1:0]   tag_d [SETS][WAYS];
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   valid_d [SETS];

  logic [WAYS-1:0]   hit_vec, inv_vec;
  logic [WL-1:0]     hit_way, free_way, plru_victim_way, victim_sel;
  logic              plru_clear, plru_access;
  logic [WL-1:0]     plru_way;
  logic [INUM-1:0]   plru_index;
  logic              stall_o, refill_o, read_l2_o;
  logic [WL-1:0]     way_o;
  logic [TNUM+INUM-1:0] l2_addr;

  plru_tree #(.WAYS(WAYS), .SETS(SETS)) u_plru (
    .clk        (clk),
    .rst        (rst),
    .clear      (plru_clear),
    .index      (plru_index),
    .access     (plru_access),
    .access_way (plru_way),
    .victim     (plru_victim_way)
  );

  // Lookup of the core's set; the lowest matching / lowest invalid way wins.
  always_comb begin
    hit_vec  = '0;
    inv_vec  = '0;
    hit_way  = '0;
    free_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_q[bus.index_C_L1][w] && (tag_q[bus.index_C_L1][w] == bus.tag_C_L1);
      inv_vec[w] = !valid_q[bus.index_C_L1][w];
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = w[WL-1:0];
      if (inv_vec[w]) free_way = w[WL-1:0];
    end
    victim_sel = (|inv_vec) ? free_way : plru_victim_way;
  end

  always_comb begin
    state_d     = state_q;
    cap_tag_d   = cap_tag_q;
    cap_index_d = cap_index_q;
    victim_d    = victim_q;
    tag_d       = tag_q;
    valid_d     = valid_q;
    plru_clear  = 1'b0;
    plru_access = 1'b0;
    plru_way    = '0;
    plru_index  = bus.index_C_L1;
    stall_o     = 1'b0;
    refill_o    = 1'b0;
    read_l2_o   = 1'b0;
    way_o       = '0;
    // Outputs stay quiet while reset is held, whatever the core is driving.
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.flush) begin
            stall_o = 1'b1;
            state_d = ST_FLUSH;
          end else if (bus.read_C_L1) begin
            if (|hit_vec) begin
              way_o       = hit_way;
              plru_access = 1'b1;
              plru_way    = hit_way;
            end else begin
              stall_o     = 1'b1;
              cap_tag_d   = bus.tag_C_L1;
              cap_index_d = bus.index_C_L1;
              victim_d    = victim_sel;
              state_d     = ST_MISS;
            end
          end
        end
        ST_MISS: begin
          stall_o   = 1'b1;
          read_l2_o = 1'b1;
          if (bus.ready_L2_L1) state_d = ST_REFILL;
        end
        ST_REFILL: begin
          stall_o                        = 1'b1;
          refill_o                       = 1'b1;
          way_o                          = victim_q;
          tag_d[cap_index_q][victim_q]   = cap_tag_q;
          valid_d[cap_index_q][victim_q] = 1'b1;
          plru_access                    = 1'b1;
          plru_way                       = victim_q;
          plru_index                     = cap_index_q;
          state_d                        = ST_IDLE;
        end
        ST_FLUSH: begin
          stall_o    = 1'b1;
          plru_clear = 1'b1;
          for (int s = 0; s < SETS; s++) valid_d[s] = '0;
          if (!bus.flush) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cap_tag_q   <= '0;
      cap_index_q <= '0;
      victim_q    <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) tag_q[s][w] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cap_tag_q   <= cap_tag_d;
      cap_index_q <= cap_index_d;
      victim_q    <= victim_d;
      valid_q     <= valid_d;
      tag_q       <= tag_d;
    end
  end

  // The captured miss address is re-split at the L2 tag/index boundary.
  assign l2_addr         = {cap_tag_q, cap_index_q};
  assign bus.tag_L1_L2   = l2_addr[TNUM+INUM-1 -: TNUM_2];
  assign bus.index_L1_L2 = l2_addr[INUM_2-1:0];
  assign bus.stall       = stall_o;
  assign bus.refill      = refill_o;
  assign bus.way         = way_o;
  assign bus.read_L1_L2  = read_l2_o;
  assign state_dbg       = state_q;

endmodule
